// File: rtl/mac_frame_parser.sv
// Parses a 64-bit Ethernet word stream into preamble, header fields and payload bytes.
// Optional define MAC_FRAME_PARSER_LEN_CHECK_EN flags frames whose length field disagrees with the payload count.
module mac_frame_parser #(
    parameter int PAYLOAD_MAX_SIZE = 1500
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [63:0] i_frame_in,
    input  logic        i_done,
    output logic [47:0] o_dest_address,
    output logic [47:0] o_src_address,
    output logic [15:0] o_eth_type,
    output logic        o_header_valid,
    output logic [7:0]  o_payload_data,
    output logic        o_payload_valid,
    output logic [15:0] o_payload_len,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_preamble_err
);
    localparam logic [63:0] PREAMBLE = 64'h55555555555555D5;
    localparam logic [15:0] LEN_MAX  = 16'(PAYLOAD_MAX_SIZE);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, DROP, DONE} state_t;

    state_t      r_state, w_next;
    logic [47:0] r_dest, r_src;
    logic [15:0] r_type, r_len;
    logic [7:0]  r_data;
    logic        r_hdr_vld, r_pay_vld, r_fdone, r_ferr, r_perr;

    logic w_cap0, w_cap1, w_accept, w_ovf, w_len_clr;
    logic w_fdone, w_ferr, w_perr, w_full, w_len_bad;

    assign w_full = (r_len >= LEN_MAX);

`ifdef MAC_FRAME_PARSER_LEN_CHECK_EN
    logic [15:0] w_len_new;
    // Compare against the count including a byte accepted in the same cycle as i_done.
    assign w_len_new = r_len + 16'(w_accept);
    assign w_len_bad = (r_type <= 16'd1500) && (w_len_new != r_type);
`else
    assign w_len_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_cap0    = 1'b0;
        w_cap1    = 1'b0;
        w_accept  = 1'b0;
        w_ovf     = 1'b0;
        w_len_clr = 1'b0;
        w_fdone   = 1'b0;
        w_ferr    = 1'b0;
        w_perr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    if (i_frame_in == PREAMBLE) begin
                        w_next    = HDR0;
                        w_len_clr = 1'b1;
                    end else begin
                        w_perr = 1'b1;
                    end
                end
            end
            HDR0, HDR1: begin
                // A truncated header wins over a coincident header word.
                if (i_done) begin
                    w_next  = DONE;
                    w_fdone = 1'b1;
                    w_ferr  = 1'b1;
                end else if (i_valid) begin
                    w_cap0 = (r_state == HDR0);
                    w_cap1 = (r_state == HDR1);
                    w_next = (r_state == HDR0) ? HDR1 : PAYLOAD;
                end
            end
            PAYLOAD: begin
                w_accept = i_valid && !w_full;
                w_ovf    = i_valid && w_full;
                if (i_done) begin
                    w_next  = DONE;
                    w_fdone = 1'b1;
                    w_ferr  = w_ovf || w_len_bad;
                end else if (w_ovf) begin
                    w_next = DROP;
                end
            end
            DROP: begin
                if (i_done) begin
                    w_next  = DONE;
                    w_fdone = 1'b1;
                    w_ferr  = 1'b1;
                end
            end
            DONE: begin
                if (!i_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_dest    <= '0;
            r_src     <= '0;
            r_type    <= '0;
            r_len     <= '0;
            r_data    <= '0;
            r_hdr_vld <= 1'b0;
            r_pay_vld <= 1'b0;
            r_fdone   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_hdr_vld <= w_cap1;
            r_pay_vld <= w_accept;
            r_fdone   <= w_fdone;
            r_ferr    <= w_ferr;
            r_perr    <= w_perr;
            if (w_len_clr) r_len <= '0;
            if (w_cap0) begin
                r_dest         <= i_frame_in[63:16];
                r_src[47:32]   <= i_frame_in[15:0];
            end
            if (w_cap1) begin
                r_src[31:0] <= i_frame_in[63:32];
                r_type      <= i_frame_in[31:16];
            end
            // Accept is gated by w_full, so the count saturates at the limit.
            if (w_accept) begin
                r_data <= i_frame_in[7:0];
                r_len  <= r_len + 16'd1;
            end
        end
    end

    assign o_dest_address  = r_dest;
    assign o_src_address   = r_src;
    assign o_eth_type      = r_type;
    assign o_header_valid  = r_hdr_vld;
    assign o_payload_data  = r_data;
    assign o_payload_valid = r_pay_vld;
    assign o_payload_len   = r_len;
    assign o_frame_done    = r_fdone;
    assign o_frame_err     = r_ferr;
    assign o_preamble_err  = r_perr;

endmodule

// File: tb/tb_mac_frame_parser.sv
// Self-checking bench for mac_frame_parser: IDLE vector table, scoreboarded frames, overflow, truncation, reset.
module tb_mac_frame_parser;
    localparam logic [63:0] PRE = 64'h55555555555555D5;
`ifdef MAC_FRAME_PARSER_LEN_CHECK_EN
    localparam logic LENCHK = 1'b1;
`else
    localparam logic LENCHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vld, done;
    logic [63:0] din;

    logic [47:0] dest, src, dest4, src4;
    logic [15:0] etype, plen, etype4, plen4;
    logic [7:0]  pdata, pdata4;
    logic        hv, pv, fd, fe, pe, hv4, pv4, fd4, fe4, pe4;

    mac_frame_parser dut (
        .clk(clk), .i_rst(rst), .i_valid(vld), .i_frame_in(din), .i_done(done),
        .o_dest_address(dest), .o_src_address(src), .o_eth_type(etype),
        .o_header_valid(hv), .o_payload_data(pdata), .o_payload_valid(pv),
        .o_payload_len(plen), .o_frame_done(fd), .o_frame_err(fe), .o_preamble_err(pe)
    );

    mac_frame_parser #(.PAYLOAD_MAX_SIZE(4)) dut4 (
        .clk(clk), .i_rst(rst), .i_valid(vld), .i_frame_in(din), .i_done(done),
        .o_dest_address(dest4), .o_src_address(src4), .o_eth_type(etype4),
        .o_header_valid(hv4), .o_payload_data(pdata4), .o_payload_valid(pv4),
        .o_payload_len(plen4), .o_frame_done(fd4), .o_frame_err(fe4), .o_preamble_err(pe4)
    );

    typedef struct { logic [47:0] dest; logic [47:0] src; logic [15:0] typ; } hdr_t;
    typedef struct { logic [15:0] len; logic err; } frm_t;
    typedef struct { logic v; logic [63:0] d; logic dn; logic exp_perr; } vec_t;

    hdr_t       hq[$];
    logic [7:0] bq[$];
    frm_t       fq[$];
    hdr_t       mh;
    frm_t       mf;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt4 = 0, done4 = 0;
    logic [15:0] len4 = '0;
    logic        err4 = 1'b0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pv) begin
            if (bq.size() == 0) chk("unexpected_payload_valid", 192'(pv), 192'(0));
            else chk("payload_byte", 192'(pdata), 192'(bq.pop_front()));
        end
        if (hv) begin
            if (hq.size() == 0) chk("unexpected_header_valid", 192'(hv), 192'(0));
            else begin
                mh = hq.pop_front();
                chk("header_fields", 192'({dest, src, etype}), 192'({mh.dest, mh.src, mh.typ}));
            end
        end
        if (fd) begin
            if (fq.size() == 0) chk("unexpected_frame_done", 192'(fd), 192'(0));
            else begin
                mf = fq.pop_front();
                chk("frame_len", 192'(plen), 192'(mf.len));
                chk("frame_err", 192'(fe), 192'(mf.err));
            end
        end
        if (pv4) cnt4++;
        if (fd4) begin
            done4++;
            len4 = plen4;
            err4 = fe4;
        end
    end

    task automatic drive(input logic v, input logic [63:0] d, input logic dn);
        vld = v; din = d; done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] ty);
        drive(1'b1, PRE, 1'b0);
        drive(1'b1, {da, sa[47:32]}, 1'b0);
        hq.push_back('{da, sa, ty});
        drive(1'b1, {sa[31:0], ty, 16'hBEEF}, 1'b0);
    endtask

    task automatic send_payload(input int n, input logic [7:0] base);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) drive(1'b0, {$urandom(), $urandom()}, 1'b0);
            w = {$urandom(), $urandom()};
            w[7:0] = base + 8'(i);
            bq.push_back(w[7:0]);
            drive(1'b1, w, 1'b0);
        end
    endtask

    task automatic end_frame(input int n, input logic err);
        fq.push_back('{16'(n), err});
        drive(1'b0, 64'd0, 1'b1);
        drive(1'b1, PRE, 1'b1);      // words while DONE is held must be ignored
        drive(1'b0, 64'd0, 1'b0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 64'h0123456789ABCDEF, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 64'h55555555555555D4, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 64'hD555555555555555, 1'b0, 1'b1};
        tbl[4] = '{1'b0, PRE,                  1'b0, 1'b0};
        tbl[5] = '{1'b1, 64'h0,                1'b1, 1'b1};

        rst = 1'b1; vld = 1'b0; din = '0; done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_fields", 192'({dest, src, etype, pdata, plen}), 192'(0));
        chk("reset_flags", 192'({hv, pv, fd, fe, pe, hv4, pv4, fd4, fe4, pe4}), 192'(0));
        chk("reset_fields_max4", 192'({dest4, src4, etype4, pdata4, plen4}), 192'(0));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].dn);
            chk($sformatf("idle_vec%0d_preamble_err", i), 192'(pe), 192'(tbl[i].exp_perr));
        end

        // Nominal frame
        send_hdr(48'h112233445566, 48'hAABBCCDDEEFF, 16'h0800);
        send_payload(46, 8'h10);
        end_frame(46, 1'b0);
        drive(1'b0, 64'd0, 1'b0);
        chk("len_hold_after_done", 192'(plen), 192'(46));

        // Overflow on the max-4 instance; the default instance takes all 6
        cnt4 = 0; done4 = 0;
        send_hdr(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800);
        send_payload(6, 8'h80);
        end_frame(6, 1'b0);
        chk("max4_bytes_out", 192'(cnt4), 192'(4));
        chk("max4_frame_done_count", 192'(done4), 192'(1));
        chk("max4_len", 192'(len4), 192'(4));
        chk("max4_err", 192'(err4), 192'(1));

        // Truncated header after HDR0
        drive(1'b1, PRE, 1'b0);
        drive(1'b1, {48'hDEADBEEF0001, 16'h2222}, 1'b0);
        end_frame(0, 1'b1);

        // Length field vs payload count
        send_hdr(48'h111111111111, 48'h222222222222, 16'h0010);
        send_payload(15, 8'h00);
        end_frame(15, LENCHK);
        send_hdr(48'h333333333333, 48'h444444444444, 16'h0010);
        send_payload(16, 8'h40);
        end_frame(16, 1'b0);

        // Reset mid-payload
        send_hdr(48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h0806);
        send_payload(3, 8'hC0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midframe_reset_fields", 192'({dest, src, etype, pdata, plen}), 192'(0));
        chk("midframe_reset_flags", 192'({hv, pv, fd, fe, pe}), 192'(0));
        chk("midframe_bytes_consumed", 192'(bq.size()), 192'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, {48'h112233445566, 16'hAABB}, 1'b0);
        chk("post_reset_needs_preamble", 192'(pe), 192'(1));
        send_hdr(48'h665544332211, 48'hFFEEDDCCBBAA, 16'h86DD);
        send_payload(5, 8'hE0);
        end_frame(5, 1'b0);

        repeat (3) drive(1'b0, 64'd0, 1'b0);
        chk("bytes_drained", 192'(bq.size()), 192'(0));
        chk("headers_drained", 192'(hq.size()), 192'(0));
        chk("frames_drained", 192'(fq.size()), 192'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mac_frame_parser.md
MAC_FRAME_PARSER -- requirements
Module: mac_frame_parser

Interface
REQ-001 SHALL have parameter PAYLOAD_MAX_SIZE, default 1500, maximum payload bytes accepted per frame.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_valid  in  1  input word qualifier.
REQ-005 SHALL have port i_frame_in  in  64  frame word stream.
REQ-006 SHALL have port i_done  in  1  transmitter frame-complete level, held high until next start.
REQ-007 SHALL have port o_dest_address  out  48  captured destination MAC.
REQ-008 SHALL have port o_src_address  out  48  captured source MAC.
REQ-009 SHALL have port o_eth_type  out  16  captured EtherType/Length.
REQ-010 SHALL have port o_header_valid  out  1  one-cycle pulse when all header fields are captured.
REQ-011 SHALL have port o_payload_data  out  8  extracted payload byte.
REQ-012 SHALL have port o_payload_valid  out  1  qualifies o_payload_data for one cycle.
REQ-013 SHALL have port o_payload_len  out  16  payload bytes counted in the current frame.
REQ-014 SHALL have port o_frame_done  out  1  one-cycle end-of-frame pulse.
REQ-015 SHALL have port o_frame_err  out  1  valid with o_frame_done; 1 means the frame was bad.
REQ-016 SHALL have port o_preamble_err  out  1  one-cycle pulse when a valid word in IDLE is not the preamble.

Function
REQ-017 SHALL implement states IDLE, HDR0, HDR1, PAYLOAD, DROP, DONE; all outputs registered with 1-cycle latency from the input cycle.
REQ-018 IDLE: i_valid and i_frame_in==64'h55555555555555D5 -> HDR0, clear o_payload_len; i_valid with any other value -> pulse o_preamble_err, stay IDLE.
REQ-019 HDR0: on i_valid, o_dest_address<=i_frame_in[63:16], o_src_address[47:32]<=i_frame_in[15:0] -> HDR1.
REQ-020 HDR1: on i_valid, o_src_address[31:0]<=i_frame_in[63:32], o_eth_type<=i_frame_in[31:16], pulse o_header_valid -> PAYLOAD; i_frame_in[15:0] ignored.
REQ-021 PAYLOAD: each i_valid word -> o_payload_data<=i_frame_in[7:0], o_payload_valid pulse, o_payload_len+1.
REQ-022 PAYLOAD: i_valid when o_payload_len==PAYLOAD_MAX_SIZE -> byte discarded, no o_payload_valid -> DROP.
REQ-023 PAYLOAD: i_done high -> DONE with o_frame_done=1, o_frame_err=0; if i_valid coincides, the byte is accepted and counted first.
REQ-024 i_done high in HDR0 or HDR1 (truncated header) -> DONE with o_frame_done=1, o_frame_err=1, o_header_valid not pulsed.
REQ-025 DROP: ignore i_valid; i_done high -> DONE with o_frame_done=1, o_frame_err=1.
REQ-026 DONE: stay while i_done high; i_done low -> IDLE; i_valid words in DONE are ignored.
REQ-027 i_valid low in HDR0/HDR1/PAYLOAD SHALL hold state and all captured fields.
REQ-028 o_payload_len SHALL saturate at PAYLOAD_MAX_SIZE, hold after o_frame_done until next preamble.

Reset
REQ-029 i_rst high SHALL force IDLE immediately, zero all outputs and counters, including mid-frame.
REQ-030 After i_rst deasserts, the first accepted frame SHALL require a fresh preamble word.

Configuration
REQ-031 Macro MAC_FRAME_PARSER_LEN_CHECK_EN defined: when o_eth_type<=1500 and o_payload_len!=o_eth_type at end of frame, o_frame_err=1 with o_frame_done.
REQ-032 Macro undefined: o_eth_type SHALL not affect o_frame_err.

Verification
REQ-033 Preamble, dest 0x112233445566, src 0xAABBCCDDEEFF, type 0x0800, 46 payload words, i_done -> header fields match, 46 o_payload_valid, o_payload_len=46, o_frame_err=0.
REQ-034 Valid word 0x0123456789ABCDEF in IDLE -> o_preamble_err pulse, state IDLE, no o_header_valid.
REQ-035 PAYLOAD_MAX_SIZE=4, 6 payload words then i_done -> 4 bytes out, o_payload_len=4, o_frame_err=1.
REQ-036 i_done after HDR0 word only -> o_frame_done=1, o_frame_err=1, no o_header_valid.
REQ-037 i_rst pulse after 3 payload bytes -> all outputs 0, IDLE; next good frame parsed correctly.
REQ-038 With MAC_FRAME_PARSER_LEN_CHECK_EN, type 0x0010 and 15 payload bytes -> o_frame_err=1; 16 bytes -> o_frame_err=0.
